// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson-code sequence decoder.
package johnson_pkg;

    localparam int unsigned MAX_WIDTH = 16;

    // Reset/home code of the widest supported ring: MSB only set.
    localparam logic [MAX_WIDTH-1:0] RESET_CODE = {1'b1, {(MAX_WIDTH-1){1'b0}}};

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } johnson_state_e;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        SKIP = 2'd3
    } step_e;

    // Width of a ring index for a WIDTH-bit Johnson word (ring length 2*WIDTH).
    function automatic int unsigned idx_w(input int unsigned width);
        return $clog2(2 * width);
    endfunction

    // MSB-only code for a ring of the given width, right-aligned.
    function automatic logic [MAX_WIDTH-1:0] reset_code(input int unsigned width);
        return RESET_CODE >> (MAX_WIDTH - width);
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson word to {legal, ring index} decoder.
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned IDX_W = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] word,
    output logic             legal_c,
    output logic [IDX_W-1:0] index_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] inv;
    logic [CNT_W-1:0] ones;

    // MSB set: word must be ones-then-zeros; MSB clear: zeros-then-ones.
    always_comb begin
        inv  = ~word;
        ones = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            ones = ones + CNT_W'(word[i]);
        end
        if (word[WIDTH-1]) begin
            legal_c = ((inv & (inv + WIDTH'(1))) == '0);
            index_c = IDX_W'(ones) - IDX_W'(1);
        end else begin
            legal_c = ((word & (word + WIDTH'(1))) == '0);
            index_c = IDX_W'(2 * WIDTH - 1) - IDX_W'(ones);
        end
    end

endmodule

// File: rtl/johnson_sequence_decoder.sv
// Johnson-code sampling decoder with step classifier, lock FSM and error counter.
module johnson_sequence_decoder
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned ERR_W      = 8,
    localparam int unsigned IDX_W     = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] johnson_in,
    input  logic             err_clr,
    output logic [IDX_W-1:0] index,
    output logic             index_valid,
    output logic             dir_up,
    output logic             step_up,
    output logic             step_down,
    output logic             illegal_err,
    output logic             skip_err,
    output logic             locked,
    output logic             fault_sticky,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned RING   = 2 * WIDTH;
    localparam int unsigned DIFF_W = IDX_W + 1;
    localparam int unsigned GOOD_W = 4;

    logic              legal_c;
    logic [IDX_W-1:0]  dec_index_c;
    logic [DIFF_W-1:0] diff_c;
    step_e             step_c;
    logic              err_event_c;

    johnson_state_e    state;
    logic [GOOD_W-1:0] good_cnt;

    johnson_code_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .word    (johnson_in),
        .legal_c (legal_c),
        .index_c (dec_index_c)
    );

    // Ring distance from the stored index and step classification.
    always_comb begin
        if (DIFF_W'(dec_index_c) >= DIFF_W'(index)) begin
            diff_c = DIFF_W'(dec_index_c) - DIFF_W'(index);
        end else begin
            diff_c = DIFF_W'(dec_index_c) + DIFF_W'(RING) - DIFF_W'(index);
        end

        step_c = HOLD;
        if (index_valid) begin
            if (diff_c == DIFF_W'(1)) begin
                step_c = UP;
            end else if (diff_c == DIFF_W'(RING - 1)) begin
                step_c = DOWN;
            end else if (diff_c != '0) begin
                step_c = SKIP;
            end
        end

        err_event_c = sample_en && (!legal_c || (step_c == SKIP));
    end

    // Decode registers, step pulses and ACQUIRE/TRACK lock FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index       <= '0;
            index_valid <= 1'b0;
            dir_up      <= 1'b1;
            step_up     <= 1'b0;
            step_down   <= 1'b0;
            illegal_err <= 1'b0;
            skip_err    <= 1'b0;
            locked      <= 1'b0;
            state       <= ACQUIRE;
            good_cnt    <= '0;
        end else begin
            step_up     <= 1'b0;
            step_down   <= 1'b0;
            illegal_err <= 1'b0;
            skip_err    <= 1'b0;
            if (sample_en) begin
                if (!legal_c) begin
                    illegal_err <= 1'b1;
                    index_valid <= 1'b0;
                    state       <= ACQUIRE;
                    locked      <= 1'b0;
                    good_cnt    <= '0;
                end else begin
                    index       <= dec_index_c;
                    index_valid <= 1'b1;
                    unique case (step_c)
                        UP: begin
                            step_up <= 1'b1;
                            dir_up  <= 1'b1;
                        end
                        DOWN: begin
                            step_down <= 1'b1;
                            dir_up    <= 1'b0;
                        end
                        SKIP:    skip_err <= 1'b1;
                        default: ;
                    endcase
                    if (step_c == SKIP) begin
                        // The skipped-to sample is itself the first good one.
                        state    <= ACQUIRE;
                        locked   <= 1'b0;
                        good_cnt <= GOOD_W'(1);
                    end else if (state == ACQUIRE) begin
                        if (good_cnt + GOOD_W'(1) >= GOOD_W'(LOCK_COUNT)) begin
                            state    <= TRACK;
                            locked   <= 1'b1;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + GOOD_W'(1);
                        end
                    end
                end
            end
        end
    end

    // Saturating error counter and sticky fault flag; clear beats a new error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count    <= '0;
            fault_sticky <= 1'b0;
        end else if (err_clr) begin
            err_count    <= '0;
            fault_sticky <= 1'b0;
        end else if (err_event_c) begin
            fault_sticky <= 1'b1;
            if (err_count != {ERR_W{1'b1}}) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_johnson_sequence_decoder.sv
// Scoreboard bench for johnson_sequence_decoder (WIDTH=4, LOCK_COUNT=3, ERR_W=2).
module tb_johnson_sequence_decoder;
    import johnson_pkg::*;

    typedef struct packed {
        logic [2:0] index;
        logic       valid;
        logic       dir;
        logic       up;
        logic       down;
        logic       ill;
        logic       skip;
        logic       locked;
        logic       sticky;
        logic [1:0] err;
    } obs_t;

    localparam logic [3:0] CODES [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                         4'b0111, 4'b0011, 4'b0001, 4'b0000};
    localparam obs_t RESET_OBS = '{index: 3'd0, valid: 1'b0, dir: 1'b1, up: 1'b0,
                                   down: 1'b0, ill: 1'b0, skip: 1'b0, locked: 1'b0,
                                   sticky: 1'b0, err: 2'd0};

    logic       clk;
    logic       rst_n;
    logic       sample_en;
    logic [3:0] johnson_in;
    logic       err_clr;
    logic [2:0] index;
    logic       index_valid;
    logic       dir_up;
    logic       step_up;
    logic       step_down;
    logic       illegal_err;
    logic       skip_err;
    logic       locked;
    logic       fault_sticky;
    logic [1:0] err_count;

    int passed = 0;
    int total  = 0;

    obs_t sb[$];

    // Reference model state
    int m_idx;
    bit m_valid;
    bit m_dir;
    bit m_locked;
    int m_good;
    int m_err;
    bit m_sticky;

    johnson_sequence_decoder #(
        .WIDTH      (4),
        .LOCK_COUNT (3),
        .ERR_W      (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_en    (sample_en),
        .johnson_in   (johnson_in),
        .err_clr      (err_clr),
        .index        (index),
        .index_valid  (index_valid),
        .dir_up       (dir_up),
        .step_up      (step_up),
        .step_down    (step_down),
        .illegal_err  (illegal_err),
        .skip_err     (skip_err),
        .locked       (locked),
        .fault_sticky (fault_sticky),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

    function automatic obs_t observe();
        return obs_t'({index, index_valid, dir_up, step_up, step_down, illegal_err,
                       skip_err, locked, fault_sticky, err_count});
    endfunction

    task automatic model_reset();
        m_idx = 0; m_valid = 0; m_dir = 1; m_locked = 0;
        m_good = 0; m_err = 0; m_sticky = 0;
        sb.delete();
    endtask

    // Advance the model by one cycle and push the expected registered outputs.
    task automatic model_push(input logic en, input logic [3:0] w, input logic clr);
        obs_t e;
        bit legal = 0;
        bit up = 0, down = 0, ill = 0, skip = 0;
        int k = 0;
        int d;
        if (en) begin
            for (int i = 0; i < 8; i++) if (CODES[i] == w) begin legal = 1; k = i; end
            if (!legal) begin
                ill = 1; m_valid = 0; m_locked = 0; m_good = 0;
            end else begin
                if (m_valid) begin
                    d    = (k - m_idx + 8) % 8;
                    up   = (d == 1);
                    down = (d == 7);
                    skip = (d != 0) && (d != 1) && (d != 7);
                end
                m_idx = k; m_valid = 1;
                if (up) m_dir = 1;
                if (down) m_dir = 0;
                if (skip) begin
                    m_locked = 0; m_good = 1;
                end else if (!m_locked) begin
                    m_good++;
                    if (m_good >= 3) begin m_locked = 1; m_good = 0; end
                end
            end
        end
        if (clr) begin
            m_err = 0; m_sticky = 0;
        end else if (ill || skip) begin
            m_sticky = 1;
            if (m_err < 3) m_err++;
        end
        e.index = 3'(m_idx); e.valid = m_valid; e.dir = m_dir;
        e.up = up; e.down = down; e.ill = ill; e.skip = skip;
        e.locked = m_locked; e.sticky = m_sticky; e.err = 2'(m_err);
        sb.push_back(e);
    endtask

    // Drive one cycle of stimulus, record the expectation, and step past the edge.
    task automatic apply(input logic en, input logic [3:0] w, input logic clr);
        sample_en  = en;
        johnson_in = w;
        err_clr    = clr;
        model_push(en, w, clr);
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0; sample_en = 1'b0; johnson_in = 4'b0000; err_clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        o = observe();
        total++;
        if (o !== RESET_OBS) $display("FAIL reset_state: got %b expected %b", o, RESET_OBS);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_up_sequence();
        logic [3:0] seq [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
        obs_t exp, o;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, seq[i], 1'b0);
            exp = sb.pop_front(); o = observe(); total++;
            if (o !== exp) $display("FAIL up_seq[%0d]: got %b expected %b", i, o, exp);
            else passed++;
        end
        total++;
        if (index !== 3'd3 || locked !== 1'b1 || err_count !== 2'd0)
            $display("FAIL up_seq_end: got idx=%0d lock=%b err=%0d expected idx=3 lock=1 err=0",
                     index, locked, err_count);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [3:0] seq [6] = '{4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
        obs_t exp, o;
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, seq[i], 1'b0);
            exp = sb.pop_front(); o = observe(); total++;
            if (o !== exp) $display("FAIL wrap[%0d]: got %b expected %b", i, o, exp);
            else passed++;
            if (i == 4) begin
                total++;
                if (step_up !== 1'b1 || index !== 3'd0)
                    $display("FAIL wrap_up: got up=%b idx=%0d expected up=1 idx=0", step_up, index);
                else passed++;
            end
        end
        total++;
        if (step_down !== 1'b1 || dir_up !== 1'b0 || index !== 3'd7)
            $display("FAIL wrap_down: got down=%b dir=%b idx=%0d expected down=1 dir=0 idx=7",
                     step_down, dir_up, index);
        else passed++;
    endtask

    task automatic test_illegal_track();
        obs_t exp, o;
        apply(1'b1, 4'b1010, 1'b0);
        exp = sb.pop_front(); o = observe(); total++;
        if (o !== exp) $display("FAIL illegal_track: got %b expected %b", o, exp);
        else passed++;
        total++;
        if (illegal_err !== 1'b1 || index_valid !== 1'b0 || locked !== 1'b0 ||
            err_count !== 2'd1 || fault_sticky !== 1'b1 || index !== 3'd7)
            $display("FAIL illegal_fields: got ill=%b val=%b lock=%b err=%0d st=%b idx=%0d expected 1 0 0 1 1 7",
                     illegal_err, index_valid, locked, err_count, fault_sticky, index);
        else passed++;
    endtask

    task automatic test_skip();
        logic [3:0] seq [6] = '{4'b0011, 4'b0001, 4'b0001, 4'b1100, 4'b1110, 4'b1111};
        obs_t exp, o;
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, seq[i], 1'b0);
            exp = sb.pop_front(); o = observe(); total++;
            if (o !== exp) $display("FAIL skip[%0d]: got %b expected %b", i, o, exp);
            else passed++;
            if (i == 3) begin
                total++;
                if (skip_err !== 1'b1 || index !== 3'd1 || locked !== 1'b0)
                    $display("FAIL skip_pulse: got skip=%b idx=%0d lock=%b expected 1 1 0",
                             skip_err, index, locked);
                else passed++;
            end
        end
        total++;
        if (locked !== 1'b1) $display("FAIL skip_relock: got locked=%b expected 1", locked);
        else passed++;
    endtask

    task automatic test_idle();
        obs_t exp, o;
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 4'b1010, 1'b0);
            exp = sb.pop_front(); o = observe(); total++;
            if (o !== exp) $display("FAIL idle[%0d]: got %b expected %b", i, o, exp);
            else passed++;
        end
    endtask

    task automatic test_saturation();
        obs_t exp, o;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) apply(1'b0, 4'b0000, 1'b1);
            else if (i < 6) apply(1'b1, 4'b1010, 1'b0);
            else apply(1'b1, 4'b1010, 1'b1);
            exp = sb.pop_front(); o = observe(); total++;
            if (o !== exp) $display("FAIL saturate[%0d]: got %b expected %b", i, o, exp);
            else passed++;
            if (i == 5) begin
                total++;
                if (err_count !== 2'd3) $display("FAIL sat_value: got %0d expected 3", err_count);
                else passed++;
            end
        end
        total++;
        if (err_count !== 2'd0 || fault_sticky !== 1'b0 || illegal_err !== 1'b1)
            $display("FAIL clear_wins: got err=%0d st=%b ill=%b expected 0 0 1",
                     err_count, fault_sticky, illegal_err);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int offs [6] = '{0, 1, 7, 1, 7, 3};
        obs_t exp, o;
        logic [3:0] w;
        logic en, clr;
        for (int i = 0; i < 60; i++) begin
            en  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) w = 4'($urandom_range(0, 15));
            else w = CODES[(m_idx + offs[$urandom_range(0, 5)]) % 8];
            apply(en, w, clr);
            exp = sb.pop_front(); o = observe(); total++;
            if (o !== exp) $display("FAIL b2b[%0d]: got %b expected %b", i, o, exp);
            else passed++;
        end
    endtask

    task automatic test_reset_midstream();
        logic [3:0] seq [4] = '{4'b1010, 4'b1000, 4'b1100, 4'b1110};
        obs_t exp, o;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, seq[i], 1'b0);
            exp = sb.pop_front(); o = observe(); total++;
            if (o !== exp) $display("FAIL pre_reset[%0d]: got %b expected %b", i, o, exp);
            else passed++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        o = observe(); total++;
        if (o !== RESET_OBS) $display("FAIL async_reset: got %b expected %b", o, RESET_OBS);
        else passed++;
        model_reset();
        #2;
        rst_n = 1'b1;
        apply(1'b1, 4'(reset_code(4)), 1'b0);
        exp = sb.pop_front(); o = observe(); total++;
        if (o !== exp) $display("FAIL post_reset: got %b expected %b", o, exp);
        else passed++;
        total++;
        if (step_up !== 1'b0 || step_down !== 1'b0 || skip_err !== 1'b0 || index_valid !== 1'b1)
            $display("FAIL new_reference: got up=%b down=%b skip=%b val=%b expected 0 0 0 1",
                     step_up, step_down, skip_err, index_valid);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_up_sequence();
        test_wrap();
        test_illegal_track();
        test_skip();
        test_idle();
        test_saturation();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
